// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side circular buffer placed directly after the UART
// receiver. Bytes are captured on the receiver's one-cycle done strobe and held
// until the consumer pops them. The read port is first-word-fall-through: the
// head byte is always visible on r_data, and rd removes it.
//
// empty/full are kept as explicit registers rather than derived from pointer
// equality, because w_ptr == r_ptr is ambiguous (it holds both when the buffer
// is empty and when it is full).
//
// Optional build macro: UART_RX_FIFO_LEVEL_EN adds a registered occupancy
// output 'level' (AW+1 bits, 0..2**AW). Without it the port and counter are
// absent and everything else behaves identically.

module uart_rx_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic [DW-1:0] w_data,
   input  logic          rd,
   output logic [DW-1:0] r_data,
   output logic          empty,
   output logic          full,
   output logic          overrun,
   input  logic          ovr_clr
`ifdef UART_RX_FIFO_LEVEL_EN
   ,
   output logic [AW:0]   level
`endif
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] w_ptr, w_ptr_next;
   logic [AW-1:0] r_ptr, r_ptr_next;
   logic [AW-1:0] w_ptr_succ, r_ptr_succ;
   logic          empty_reg, empty_next;
   logic          full_reg, full_next;
   logic          overrun_reg, overrun_next;
   logic          do_wr, do_rd, drop;

`ifdef UART_RX_FIFO_LEVEL_EN
   logic [AW:0]   level_reg, level_next;
`endif

   // Decide which operations are accepted this cycle and compute the next
   // pointer, status and overrun values.
   always_comb begin
      w_ptr_succ   = w_ptr + 1'b1;
      r_ptr_succ   = r_ptr + 1'b1;
      // A pop from an empty buffer is ignored. A write into a full buffer is
      // only accepted when a pop frees the head slot in the same cycle.
      do_rd        = rd & ~empty_reg;
      do_wr        = wr & (~full_reg | do_rd);
      drop         = wr & full_reg & ~do_rd;

      w_ptr_next   = w_ptr;
      r_ptr_next   = r_ptr;
      empty_next   = empty_reg;
      full_next    = full_reg;
`ifdef UART_RX_FIFO_LEVEL_EN
      level_next   = level_reg;
`endif

      case ({do_wr, do_rd})
         2'b10: begin
            w_ptr_next = w_ptr_succ;
            empty_next = 1'b0;
            full_next  = (w_ptr_succ == r_ptr);
`ifdef UART_RX_FIFO_LEVEL_EN
            level_next = level_reg + 1'b1;
`endif
         end
         2'b01: begin
            r_ptr_next = r_ptr_succ;
            full_next  = 1'b0;
            empty_next = (r_ptr_succ == w_ptr);
`ifdef UART_RX_FIFO_LEVEL_EN
            level_next = level_reg - 1'b1;
`endif
         end
         2'b11: begin
            // Occupancy is unchanged, so both status flags hold.
            w_ptr_next = w_ptr_succ;
            r_ptr_next = r_ptr_succ;
         end
         default: begin
         end
      endcase

      // A dropped write takes priority over a clear in the same cycle so that
      // a loss is never hidden.
      if (drop) begin
         overrun_next = 1'b1;
      end else if (ovr_clr) begin
         overrun_next = 1'b0;
      end else begin
         overrun_next = overrun_reg;
      end
   end

   // Pointer, status and overrun registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_ptr       <= '0;
         r_ptr       <= '0;
         empty_reg   <= 1'b1;
         full_reg    <= 1'b0;
         overrun_reg <= 1'b0;
`ifdef UART_RX_FIFO_LEVEL_EN
         level_reg   <= '0;
`endif
      end else begin
         w_ptr       <= w_ptr_next;
         r_ptr       <= r_ptr_next;
         empty_reg   <= empty_next;
         full_reg    <= full_next;
         overrun_reg <= overrun_next;
`ifdef UART_RX_FIFO_LEVEL_EN
         level_reg   <= level_next;
`endif
      end
   end

   // Storage array; deliberately not reset, contents become stale after reset
   // because the pointers return to zero.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[w_ptr] <= w_data;
      end
   end

   assign r_data  = mem[r_ptr];
   assign empty   = empty_reg;
   assign full    = full_reg;
   assign overrun = overrun_reg;
`ifdef UART_RX_FIFO_LEVEL_EN
   assign level   = level_reg;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed testbench for uart_rx_fifo (DW=8, AW=4).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
// Build with UART_RX_FIFO_LEVEL_EN defined to also check the level port.

module tb_uart_rx_fifo;

   logic       clk;
   logic       rst;
   logic       wr;
   logic [7:0] w_data;
   logic       rd;
   logic [7:0] r_data;
   logic       empty;
   logic       full;
   logic       overrun;
   logic       ovr_clr;
`ifdef UART_RX_FIFO_LEVEL_EN
   logic [4:0] level;
`endif

   int vectors;
   int miscompares;

   uart_rx_fifo #(.DW(8), .AW(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr),
      .w_data  (w_data),
      .rd      (rd),
      .r_data  (r_data),
      .empty   (empty),
      .full    (full),
      .overrun (overrun),
      .ovr_clr (ovr_clr)
`ifdef UART_RX_FIFO_LEVEL_EN
      ,
      .level   (level)
`endif
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr     = 1'b1;
      w_data = d;
      tick();
      wr     = 1'b0;
   endtask

   task automatic pop();
      rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr = 1'b0; rd = 1'b0; ovr_clr = 1'b0; w_data = 8'h00;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
      vectors++;
      if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
`ifdef UART_RX_FIFO_LEVEL_EN
      vectors++;
      if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
`endif
   endtask

   task automatic test_basic();
      push(8'h55);
      vectors++;
      if (empty !== 1'b0) begin miscompares++; $display("FAIL basic_empty_after_wr: got %b want 0", empty); end
      vectors++;
      if (r_data !== 8'h55) begin miscompares++; $display("FAIL basic_head1: got %h want 55", r_data); end
      push(8'hA3);
      vectors++;
      if (r_data !== 8'h55) begin miscompares++; $display("FAIL basic_head_before_pop: got %h want 55", r_data); end
`ifdef UART_RX_FIFO_LEVEL_EN
      vectors++;
      if (level !== 5'd2) begin miscompares++; $display("FAIL basic_level2: got %0d want 2", level); end
`endif
      pop();
      vectors++;
      if (r_data !== 8'hA3) begin miscompares++; $display("FAIL basic_head_after_pop: got %h want a3", r_data); end
      vectors++;
      if (empty !== 1'b0) begin miscompares++; $display("FAIL basic_empty_one_left: got %b want 0", empty); end
      pop();
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty_final: got %b want 1", empty); end
      // pop on empty must be ignored
      pop();
      vectors++;
      if (empty !== 1'b1 || full !== 1'b0) begin
         miscompares++; $display("FAIL basic_pop_on_empty: got empty=%b full=%b want 1/0", empty, full);
      end
   endtask

   task automatic test_fill_overrun();
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (full !== 1'b0) begin miscompares++; $display("FAIL fill_full_early[%0d]: got %b want 0", i, full); end
         push(8'(i));
      end
      vectors++;
      if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", full); end
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL fill_overrun_pre: got %b want 0", overrun); end
`ifdef UART_RX_FIFO_LEVEL_EN
      vectors++;
      if (level !== 5'd16) begin miscompares++; $display("FAIL fill_level16: got %0d want 16", level); end
`endif
      push(8'hFF);
      vectors++;
      if (overrun !== 1'b1) begin miscompares++; $display("FAIL fill_overrun_set: got %b want 1", overrun); end
      vectors++;
      if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full_after_drop: got %b want 1", full); end
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (r_data !== 8'(i)) begin miscompares++; $display("FAIL fill_pop_data[%0d]: got %h want %h", i, r_data, 8'(i)); end
         pop();
      end
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("FAIL fill_empty_after_drain: got %b want 1", empty); end
      vectors++;
      if (overrun !== 1'b1) begin miscompares++; $display("FAIL fill_overrun_sticky: got %b want 1", overrun); end
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clr: got %b want 0", overrun); end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < 16; i++) push(8'(i));
      wr = 1'b1; rd = 1'b1; w_data = 8'h77;
      tick();
      wr = 1'b0; rd = 1'b0;
      vectors++;
      if (full !== 1'b1) begin miscompares++; $display("FAIL simul_full_stays: got %b want 1", full); end
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL simul_full_no_overrun: got %b want 0", overrun); end
`ifdef UART_RX_FIFO_LEVEL_EN
      vectors++;
      if (level !== 5'd16) begin miscompares++; $display("FAIL simul_full_level: got %0d want 16", level); end
`endif
      for (int i = 1; i < 17; i++) begin
         logic [7:0] exp;
         exp = (i == 16) ? 8'h77 : 8'(i);
         vectors++;
         if (r_data !== exp) begin miscompares++; $display("FAIL simul_full_order[%0d]: got %h want %h", i, r_data, exp); end
         pop();
      end
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("FAIL simul_full_drain_empty: got %b want 1", empty); end
   endtask

   task automatic test_empty_simul();
      wr = 1'b1; rd = 1'b1; w_data = 8'h3C;
      tick();
      wr = 1'b0; rd = 1'b0;
      vectors++;
      if (empty !== 1'b0) begin miscompares++; $display("FAIL simul_empty_flag: got %b want 0", empty); end
      vectors++;
      if (r_data !== 8'h3C) begin miscompares++; $display("FAIL simul_empty_data: got %h want 3c", r_data); end
`ifdef UART_RX_FIFO_LEVEL_EN
      vectors++;
      if (level !== 5'd1) begin miscompares++; $display("FAIL simul_empty_level: got %0d want 1", level); end
`endif
      pop();
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("FAIL simul_empty_drain: got %b want 1", empty); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 40; i++) begin
         logic [7:0] d;
         d = 8'((i * 7 + 3) & 8'hFF);
         push(d);
         vectors++;
         if (r_data !== d || empty !== 1'b0) begin
            miscompares++; $display("FAIL wrap_data[%0d]: got %h empty=%b want %h empty=0", i, r_data, empty, d);
         end
         pop();
         vectors++;
         if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty[%0d]: got %b want 1", i, empty); end
      end
   endtask

   task automatic test_ovr_coincide();
      for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
      wr = 1'b1; w_data = 8'hFF; ovr_clr = 1'b1;
      tick();
      wr = 1'b0; ovr_clr = 1'b0;
      vectors++;
      if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
      vectors++;
      if (r_data !== 8'h80) begin miscompares++; $display("FAIL ovr_head_intact: got %h want 80", r_data); end
   endtask

   task automatic test_reset_mid();
      // buffer is full with overrun set from the previous scenario
      rst = 1'b1;
      #2;
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("FAIL midrst_empty: got %b want 1", empty); end
      vectors++;
      if (full !== 1'b0) begin miscompares++; $display("FAIL midrst_full: got %b want 0", full); end
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
`ifdef UART_RX_FIFO_LEVEL_EN
      vectors++;
      if (level !== 5'd0) begin miscompares++; $display("FAIL midrst_level: got %0d want 0", level); end
`endif
      rst = 1'b0;
      tick();
      push(8'h9D);
      vectors++;
      if (r_data !== 8'h9D || empty !== 1'b0) begin
         miscompares++; $display("FAIL midrst_after: got %h empty=%b want 9d empty=0", r_data, empty);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_basic();
      test_fill_overrun();
      test_full_simul();
      test_empty_simul();
      test_wrap();
      test_ovr_coincide();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
